// File: rtl/eyeriss_row_scheduler.sv
// Row-stationary PE scheduler: loads one filter row and one ifmap row,
// then sequences the MAC taps and psum handoff for every output position.
module eyeriss_row_scheduler #(
    parameter int FILT_W  = 3,
    parameter int IFMAP_W = 8,
    localparam int OUT_W  = IFMAP_W - FILT_W + 1,
    localparam int AW_W   = (FILT_W > 1) ? $clog2(FILT_W) : 1,
    localparam int AW_I   = (IFMAP_W > 1) ? $clog2(IFMAP_W) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            w_we,
    output logic [AW_W-1:0] w_addr,
    output logic            i_we,
    output logic [AW_I-1:0] i_addr,
    output logic            mac_en,
    output logic            acc_clr,
    output logic            psum_valid,
    input  logic            psum_ready,
    output logic [AW_I-1:0] out_idx
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        LOAD_I,
        MAC,
        EMIT,
        DONE
    } state_t;

    state_t          state, state_n;
    logic [AW_W-1:0] k, k_n;
    logic [AW_I-1:0] o, o_n;
    logic [AW_I-1:0] lc, lc_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
            o     <= '0;
            lc    <= '0;
        end else begin
            state <= state_n;
            k     <= k_n;
            o     <= o_n;
            lc    <= lc_n;
        end
    end

    always_comb begin
        state_n    = state;
        k_n        = k;
        o_n        = o;
        lc_n       = lc;
        busy       = (state != IDLE);
        done       = 1'b0;
        in_ready   = 1'b0;
        w_we       = 1'b0;
        i_we       = 1'b0;
        mac_en     = 1'b0;
        acc_clr    = 1'b0;
        psum_valid = 1'b0;
        w_addr     = '0;
        i_addr     = '0;
        out_idx    = '0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = LOAD_W;
                    k_n     = '0;
                    o_n     = '0;
                    lc_n    = '0;
                end
            end
            LOAD_W: begin
                in_ready = 1'b1;
                w_we     = in_valid;
                w_addr   = lc[AW_W-1:0];
                if (in_valid) begin
                    if (lc == AW_I'(FILT_W - 1)) begin
                        lc_n    = '0;
                        state_n = LOAD_I;
                    end else begin
                        lc_n = lc + AW_I'(1);
                    end
                end
            end
            LOAD_I: begin
                in_ready = 1'b1;
                i_we     = in_valid;
                i_addr   = lc;
                if (in_valid) begin
                    if (lc == AW_I'(IFMAP_W - 1)) begin
                        lc_n    = '0;
                        k_n     = '0;
                        o_n     = '0;
                        state_n = MAC;
                    end else begin
                        lc_n = lc + AW_I'(1);
                    end
                end
            end
            MAC: begin
                mac_en  = 1'b1;
                w_addr  = k;
                // ifmap window slides with the output index
                i_addr  = o + AW_I'(k);
                acc_clr = (k == '0);
                out_idx = o;
                if (k == AW_W'(FILT_W - 1)) begin
                    k_n     = '0;
                    state_n = EMIT;
                end else begin
                    k_n = k + AW_W'(1);
                end
            end
            EMIT: begin
                psum_valid = 1'b1;
                out_idx    = o;
                if (psum_ready) begin
                    if (o == AW_I'(OUT_W - 1)) begin
                        state_n = DONE;
                    end else begin
                        o_n     = o + AW_I'(1);
                        state_n = MAC;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                out_idx = o;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: doc/eyeriss_row_scheduler.md
EYERISS_ROW_SCHEDULER -- requirements
Module: eyeriss_row_scheduler

Interface
REQ-001 Parameter FILT_W, default 3, filter row width in taps; legal range 1..IFMAP_W.
REQ-002 Parameter IFMAP_W, default 8, ifmap row width in pixels; legal range 1..16.
REQ-003 Derived OUT_W = IFMAP_W-FILT_W+1 is the output psums per row; AW_W = max(1,clog2(FILT_W)) and AW_I = max(1,clog2(IFMAP_W)).
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 start  in  1  begin one row job; sampled only in IDLE.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 done  out  1  one-cycle pulse at job completion.
REQ-010 in_valid  in  1  upstream word valid; carries weights, then ifmap pixels.
REQ-011 in_ready  out  1  scheduler accepts an upstream word.
REQ-012 w_we  out  1  weight scratchpad write strobe.
REQ-013 w_addr  out  AW_W  weight scratchpad address, used for both write and read.
REQ-014 i_we  out  1  ifmap scratchpad write strobe.
REQ-015 i_addr  out  AW_I  ifmap scratchpad address, used for both write and read.
REQ-016 mac_en  out  1  PE multiply-accumulate enable.
REQ-017 acc_clr  out  1  PE accumulator loads the product instead of adding it.
REQ-018 psum_valid  out  1  PE psum is presented downstream.
REQ-019 psum_ready  in  1  downstream accepts the psum.
REQ-020 out_idx  out  AW_I  index of the psum being computed or emitted.

Function
REQ-021 States SHALL be IDLE, LOAD_W, LOAD_I, MAC, EMIT and DONE; the state, tap counter k, output counter o and load counter SHALL be registers.
REQ-022 IDLE: when start=1, go to LOAD_W and clear all counters; otherwise stay in IDLE.
REQ-023 LOAD_W: in_ready=1; w_we=in_valid; w_addr=load counter; on each handshake, increment the counter; the handshake at count FILT_W-1 clears the counter and goes to LOAD_I.
REQ-024 LOAD_I: in_ready=1; i_we=in_valid; i_addr=load counter; the handshake at count IFMAP_W-1 goes to MAC with k=0 and o=0.
REQ-025 Without a handshake (in_valid=0), the counters and state SHALL hold; no write strobe is asserted.
REQ-026 MAC: mac_en=1; w_addr=k; i_addr=o+k; acc_clr=1 only when k=0; k increments every cycle; after k=FILT_W-1, go to EMIT and reset k to 0.
REQ-027 EMIT: psum_valid=1 is held until psum_ready=1. On that handshake: if o=OUT_W-1, go to DONE; otherwise increment o and go to MAC.
REQ-028 DONE: done=1 for exactly one cycle, then go to IDLE.
REQ-029 out_idx SHALL equal o in MAC, EMIT and DONE, and 0 elsewhere.
REQ-030 in_ready, w_we, i_we, mac_en, acc_clr and psum_valid SHALL be 0 in every state not listed for them above.
REQ-031 start asserted while busy=1 SHALL be ignored.
REQ-032 FILT_W=1: each MAC phase is 1 cycle with acc_clr=1.
REQ-033 FILT_W=IFMAP_W: OUT_W=1, giving a single MAC/EMIT pass.
REQ-034 Latency with in_valid and psum_ready held high, counting the cycle start is sampled as cycle 0:
- cycles 1..FILT_W are LOAD_W;
- the next IFMAP_W cycles are LOAD_I;
- each output then takes FILT_W MAC cycles plus 1 EMIT cycle;
- done is high in cycle FILT_W+IFMAP_W+OUT_W*(FILT_W+1)+1.
REQ-035 i_addr SHALL never exceed IFMAP_W-1, and w_addr SHALL never exceed FILT_W-1.

Reset
REQ-036 rst=1 at a clock edge SHALL force IDLE and clear all counters, in any state, including mid-load, mid-MAC and EMIT with psum_valid pending.
REQ-037 After reset, all outputs SHALL be 0: busy, done, in_ready, w_we, i_we, mac_en, acc_clr, psum_valid, w_addr, i_addr and out_idx.
REQ-038 rst SHALL take priority over start on the same edge.

Verification
REQ-039 Defaults, start pulse at cycle 0, in_valid=1, psum_ready=1 -> done high in cycle 36 only; exactly 6 psum_valid handshakes with out_idx 0..5.
REQ-040 Defaults, third output (o=2) -> MAC cycles show (w_addr,i_addr) = (0,2),(1,3),(2,4), with acc_clr only on the first.
REQ-041 in_valid toggling 1,0 during loads -> exactly 3 w_we and 8 i_we pulses, with addresses 0..2 and 0..7 in order and no duplicates.
REQ-042 psum_ready held 0 for 5 cycles in EMIT -> psum_valid stays high, out_idx is stable, no mac_en; MAC resumes the cycle after the handshake.
REQ-043 rst asserted during the MAC phase of o=3 -> next cycle all outputs are 0 and busy=0; a new start then runs a full job to done.
REQ-044 FILT_W=1, IFMAP_W=1 -> job is LOAD_W, LOAD_I, MAC, EMIT, DONE, with done high in cycle 5.
